// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Brief    : Shared state encoding and drain-time helper for systolic_seq.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    // Read pipe + row/column skew + hop walk to the far PE + accumulate.
    function automatic int drain_cycles(input int n, input int hop, input int acc_lat);
        return 1 + 2 * (n - 1) * hop + acc_lat - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_seq_skew_line.sv
`default_nettype none
// ============================================================================
// Module   : skew_line
// Brief    : DEPTH-stage delay of {valid, data} with synchronous clear;
//            output data is forced to zero whenever valid is low.
// Revision : 1.0 - initial release
// ============================================================================
module skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);

    logic             vld_tap;
    logic [WIDTH-1:0] data_tap;

    generate
        if (DEPTH == 0) begin : g_wire
            assign vld_tap  = vld_i;
            assign data_tap = data_i;
        end else begin : g_shift
            logic [DEPTH-1:0] vld_q;
            logic [WIDTH-1:0] data_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int d = 0; d < DEPTH; d++) begin
                        data_q[d] <= '0;
                    end
                end else begin
                    vld_q[0]  <= vld_i;
                    data_q[0] <= data_i;
                    for (int d = 1; d < DEPTH; d++) begin
                        vld_q[d]  <= vld_q[d-1];
                        data_q[d] <= data_q[d-1];
                    end
                end
            end

            assign vld_tap  = vld_q[DEPTH-1];
            assign data_tap = data_q[DEPTH-1];
        end
    endgenerate

    assign vld_o  = vld_tap;
    assign data_o = vld_tap ? data_tap : '0;

endmodule
`default_nettype wire

// File: rtl/systolic_seq.sv
`default_nettype none
// ============================================================================
// Module   : systolic_seq
// Brief    : Operand sequencer for an N x N systolic MAC array: clear, stream
//            k slices with per-row/column skew, drain, then pulse done.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_seq
    import systolic_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int K_MAX   = 16,
    parameter int HOP     = 3,
    parameter int ACC_LAT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(K_MAX+1)-1:0] k_len,
    output logic                       busy,
    output logic                       done,
    output logic                       buf_rd_en,
    output logic [$clog2(K_MAX)-1:0]   buf_rd_addr,
    input  logic [N*WIDTH-1:0]         a_rd_data,
    input  logic [N*WIDTH-1:0]         b_rd_data,
    output logic                       acc_clear,
    output logic [N*WIDTH-1:0]         a_row,
    output logic [N-1:0]               a_row_vld,
    output logic [N*WIDTH-1:0]         b_col,
    output logic [N-1:0]               b_col_vld
);

    localparam int KW        = $clog2(K_MAX + 1);
    localparam int AW        = $clog2(K_MAX);
    localparam int DRAIN_CYC = drain_cycles(N, HOP, ACC_LAT);
    localparam int DW        = $clog2(DRAIN_CYC + 1);

    seq_state_e    state_q, state_d;
    logic [KW-1:0] klen_q, klen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          rd_vld_q;
    logic          last_rd;

    assign last_rd     = (KW'(addr_q) == (klen_q - 1'b1));
    assign buf_rd_addr = addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            klen_q   <= '0;
            addr_q   <= '0;
            drain_q  <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            klen_q   <= klen_d;
            addr_q   <= addr_d;
            drain_q  <= drain_d;
            rd_vld_q <= buf_rd_en;
        end
    end

    always_comb begin
        state_d   = state_q;
        klen_d    = klen_q;
        addr_d    = addr_q;
        drain_d   = drain_q;
        busy      = 1'b0;
        done      = 1'b0;
        buf_rd_en = 1'b0;
        acc_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    klen_d  = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                busy      = 1'b1;
                acc_clear = 1'b1;
                addr_d    = '0;
                state_d   = (klen_q == '0) ? DONE : FEED;
            end
            FEED: begin
                busy      = 1'b1;
                buf_rd_en = 1'b1;
                if (last_rd) begin
                    addr_d  = '0;
                    drain_d = DW'(DRAIN_CYC);
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer data lands one cycle after the strobe; rd_vld_q tags it.
    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            skew_line #(.WIDTH(WIDTH), .DEPTH(i * HOP)) u_a_skew (
                .clk    (clk),
                .rst    (reset),
                .vld_i  (rd_vld_q),
                .data_i (a_rd_data[i*WIDTH +: WIDTH]),
                .vld_o  (a_row_vld[i]),
                .data_o (a_row[i*WIDTH +: WIDTH])
            );
            skew_line #(.WIDTH(WIDTH), .DEPTH(i * HOP)) u_b_skew (
                .clk    (clk),
                .rst    (reset),
                .vld_i  (rd_vld_q),
                .data_i (b_rd_data[i*WIDTH +: WIDTH]),
                .vld_o  (b_col_vld[i]),
                .data_o (b_col[i*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_seq
// Brief    : Self-checking bench for systolic_seq with a buffer model and a
//            cycle-level timeline plus systolic-array product model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_seq;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int K_MAX   = 16;
    localparam int HOP     = 3;
    localparam int ACC_LAT = 3;
    localparam int KW      = $clog2(K_MAX + 1);
    localparam int AW      = $clog2(K_MAX);
    localparam int DRAIN   = 1 + 2 * (N - 1) * HOP + ACC_LAT - 1;

    typedef struct {
        int kin;
        int pat;
        int exp_reads;
        int exp_lat;
        int mode;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [KW-1:0]  k_len = '0;
    logic           busy, done, buf_rd_en, acc_clear;
    logic [AW-1:0]  buf_rd_addr;
    logic [N*W-1:0] a_rd_data, b_rd_data, a_row, b_col;
    logic [N-1:0]   a_row_vld, b_col_vld;

    int total = 0;
    int bad   = 0;

    logic [7:0]     A_m [K_MAX][N];
    logic [7:0]     B_m [K_MAX][N];
    logic [3:0]     tr_ctl  [64];
    logic [AW-1:0]  tr_addr [64];
    logic [N-1:0]   tr_av   [64];
    logic [N-1:0]   tr_bv   [64];
    logic [N*W-1:0] tr_a    [64];
    logic [N*W-1:0] tr_b    [64];
    vec_t           vecs    [6];

    always #5 clk = ~clk;

    systolic_seq #(.N(N), .WIDTH(W), .K_MAX(K_MAX), .HOP(HOP), .ACC_LAT(ACC_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .k_len       (k_len),
        .busy        (busy),
        .done        (done),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .a_rd_data   (a_rd_data),
        .b_rd_data   (b_rd_data),
        .acc_clear   (acc_clear),
        .a_row       (a_row),
        .a_row_vld   (a_row_vld),
        .b_col       (b_col),
        .b_col_vld   (b_col_vld)
    );

    // Operand buffers: one-cycle read latency.
    always @(posedge clk) begin
        if (buf_rd_en) begin
            for (int i = 0; i < N; i++) begin
                a_rd_data[i*W +: W] <= A_m[buf_rd_addr][i];
                b_rd_data[i*W +: W] <= B_m[buf_rd_addr][i];
            end
        end
    end

    task automatic chk(input string name, input int t, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, t, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_ctl"}, 0, {busy, done, acc_clear, buf_rd_en}, 4'b0000);
        chk({name, "_addr"}, 0, buf_rd_addr, 0);
        chk({name, "_vld"}, 0, {a_row_vld, b_col_vld}, 0);
        chk({name, "_data"}, 0, {a_row, b_col}, 0);
    endtask

    task automatic fill(input int pat);
        for (int k = 0; k < K_MAX; k++) begin
            for (int i = 0; i < N; i++) begin
                case (pat)
                    0: begin
                        A_m[k][i] = (i == k) ? 8'd1 : 8'd0;
                        B_m[k][i] = 8'(k * 4 + i);
                    end
                    1: begin
                        A_m[k][i] = 8'hFF;
                        B_m[k][i] = 8'hFF;
                    end
                    default: begin
                        A_m[k][i] = 8'($urandom);
                        B_m[k][i] = 8'($urandom);
                    end
                endcase
            end
        end
    endtask

    // mode 1 adds start pulses in FEED, in the DONE cycle and right after done.
    task automatic run_op(input int kin, input int pat, input int exp_reads, input int exp_lat, input int mode);
        int kq, last, reads, pair_err, s, ta, tbi, x, y;
        logic av, bv, v;
        int c_mod [N][N];
        int c_ref [N][N];
        logic [3:0]     ectl;
        logic [N-1:0]   eav, ebv;
        logic [N*W-1:0] ea, eb;

        kq   = (kin > K_MAX) ? K_MAX : kin;
        last = exp_lat + 3;
        fill(pat);
        for (int t = 0; t < 64; t++) begin
            tr_ctl[t] = '0; tr_addr[t] = '0; tr_av[t] = '0;
            tr_bv[t] = '0;  tr_a[t] = '0;    tr_b[t] = '0;
        end

        @(negedge clk);
        start = 1'b1;
        k_len = KW'(kin);
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            tr_ctl[t]  = {busy, done, acc_clear, buf_rd_en};
            tr_addr[t] = buf_rd_addr;
            tr_av[t]   = a_row_vld;
            tr_bv[t]   = b_col_vld;
            tr_a[t]    = a_row;
            tr_b[t]    = b_col;
            start = 1'b0;
            if (mode == 1 && (t == 4 || t == exp_lat || t == exp_lat + 1)) begin
                start = 1'b1;
                k_len = '0;
            end
        end
        start = 1'b0;

        reads = 0;
        for (int t = 1; t <= last; t++) begin
            if (t <= exp_lat)
                ectl = {t < exp_lat, t == exp_lat, t == 1, (t >= 2) && (t < 2 + kq)};
            else if (mode == 1 && t == exp_lat + 2)
                ectl = 4'b1010;
            else if (mode == 1 && t == exp_lat + 3)
                ectl = 4'b0100;
            else
                ectl = 4'b0000;
            chk("ctl{busy,done,clr,rd}", t, tr_ctl[t], ectl);
            if (tr_ctl[t][0]) begin
                reads++;
                chk("rd_addr", t, tr_addr[t], t - 2);
            end
            ea = '0; eb = '0;
            for (int i = 0; i < N; i++) begin
                s = t - 3 - i * HOP;
                v = (s >= 0) && (s < kq);
                eav[i] = v;
                ebv[i] = v;
                if (v) begin
                    ea[i*W +: W] = A_m[s][i];
                    eb[i*W +: W] = B_m[s][i];
                end
            end
            chk("a_row_vld", t, tr_av[t], eav);
            chk("a_row", t, tr_a[t], ea);
            chk("b_col_vld", t, tr_bv[t], ebv);
            chk("b_col", t, tr_b[t], eb);
        end
        chk("read_count", kin, reads, exp_reads);

        // Array model: PE(i,j) sees row i after j hops and column j after i hops.
        pair_err = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c_mod[i][j] = 0;
                c_ref[i][j] = 0;
                for (int k = 0; k < kq; k++) begin
                    x = int'(A_m[k][i]);
                    y = int'(B_m[k][j]);
                    c_ref[i][j] += x * y;
                end
            end
        end
        for (int tau = 1; tau <= exp_lat - ACC_LAT; tau++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    ta  = tau - j * HOP;
                    tbi = tau - i * HOP;
                    av  = 1'b0;
                    bv  = 1'b0;
                    if (ta >= 1)  av = tr_av[ta][i];
                    if (tbi >= 1) bv = tr_bv[tbi][j];
                    if (av != bv) begin
                        pair_err++;
                    end else if (av) begin
                        x = int'(tr_a[ta][i*W +: W]);
                        y = int'(tr_b[tbi][j*W +: W]);
                        c_mod[i][j] += x * y;
                    end
                end
            end
        end
        chk("pe_pairing", kin, pair_err, 0);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                chk("C_elem", i * N + j, c_mod[i][j], c_ref[i][j]);
            end
        end
    endtask

    initial begin
        vecs[0] = '{kin: 4,  pat: 0, exp_reads: 4,  exp_lat: 28, mode: 0};
        vecs[1] = '{kin: 0,  pat: 2, exp_reads: 0,  exp_lat: 2,  mode: 0};
        vecs[2] = '{kin: 20, pat: 2, exp_reads: 16, exp_lat: 40, mode: 0};
        vecs[3] = '{kin: 6,  pat: 2, exp_reads: 6,  exp_lat: 30, mode: 1};
        vecs[4] = '{kin: 16, pat: 1, exp_reads: 16, exp_lat: 40, mode: 0};
        vecs[5] = '{kin: 1,  pat: 2, exp_reads: 1,  exp_lat: 25, mode: 0};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");

        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].kin, vecs[v].pat, vecs[v].exp_reads, vecs[v].exp_lat, vecs[v].mode);
        end

        // Reset while streaming slice k=2.
        fill(2);
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(8);
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mid_feed_addr", 4, buf_rd_addr, 2);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_mid_reset");
        run_op(3, 2, 3, 27, 0);

        for (int r = 0; r < 4; r++) begin
            int kr;
            kr = int'($urandom_range(1, K_MAX));
            run_op(kr, 2, kr, kr + 3 + DRAIN, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
